serial_adder: RTL and testbench

- Bit-serial N-bit adder: accepts two WIDTH-bit operands and a carry-in, then adds them LSB-first over WIDTH cycles.
- Uses one full-adder slice (half_adder pair plus OR) and a carry flip-flop.
- Sits downstream of the half_adder / full-adder cells as the first sequential arithmetic stage.
- Feeds a consumer through a valid/ready result handshake.
- Trades latency for area against a ripple adder.

---
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one full-adder slice.
// Computes {cout, sum} = a + b + cin over WIDTH RUN cycles.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_valid/_ready  operand handshake (ready only in IDLE)
//   a, b, cin           operands, sampled on accept only
//   sum, cout           result, meaningful while done_valid is high
//   done_valid/_ready   result handshake
//   busy                high in RUN and DONE
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic             cout_q;
    logic [CNT_W-1:0] cnt_q;

    // Full-adder slice built from two half adders plus an OR.
    logic ha0_s, ha0_c, ha1_s, ha1_c;
    logic s_c, c_next_c;

    assign ha0_s    = a_q[0] ^ b_q[0];
    assign ha0_c    = a_q[0] & b_q[0];
    assign ha1_s    = ha0_s ^ c_q;
    assign ha1_c    = ha0_s & c_q;
    assign s_c      = ha1_s;
    assign c_next_c = ha0_c | ha1_c;

    // Handshake outputs decoded from the state register only.
    assign start_ready = (state_q == IDLE);
    assign done_valid  = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign sum         = sum_q;
    assign cout        = cout_q;

    // Control FSM and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        c_q     <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= c_next_c;
                    sum_q <= {s_c, sum_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + CNT_W'(1);
                    // This edge produces the final bit.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        cout_q  <= c_next_c;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed bench for serial_adder (WIDTH=8 and WIDTH=4 instances).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       d8_start_valid = 1'b0;
    logic       d8_start_ready;
    logic [7:0] d8_a = '0;
    logic [7:0] d8_b = '0;
    logic       d8_cin = 1'b0;
    logic [7:0] d8_sum;
    logic       d8_cout;
    logic       d8_done_valid;
    logic       d8_done_ready = 1'b1;
    logic       d8_busy;

    logic       d4_start_valid = 1'b0;
    logic       d4_start_ready;
    logic [3:0] d4_a = '0;
    logic [3:0] d4_b = '0;
    logic       d4_cin = 1'b0;
    logic [3:0] d4_sum;
    logic       d4_cout;
    logic       d4_done_valid;
    logic       d4_done_ready = 1'b1;
    logic       d4_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (d8_start_valid),
        .start_ready (d8_start_ready),
        .a           (d8_a),
        .b           (d8_b),
        .cin         (d8_cin),
        .sum         (d8_sum),
        .cout        (d8_cout),
        .done_valid  (d8_done_valid),
        .done_ready  (d8_done_ready),
        .busy        (d8_busy)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (d4_start_valid),
        .start_ready (d4_start_ready),
        .a           (d4_a),
        .b           (d4_b),
        .cin         (d4_cin),
        .sum         (d4_sum),
        .cout        (d4_cout),
        .done_valid  (d4_done_valid),
        .done_ready  (d4_done_ready),
        .busy        (d4_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the 8-bit instance: idle / computing N cycles / holding result.
    bit       m_idle = 1'b1;
    bit       m_done = 1'b0;
    int       m_left = 0;
    logic [8:0] m_res  = '0;
    logic [8:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle <= 1'b1;
            m_done <= 1'b0;
            m_left <= 0;
            m_res  <= '0;
        end else if (m_idle) begin
            if (d8_start_valid) begin
                m_idle <= 1'b0;
                m_left <= 8;
                m_pend <= 9'(d8_a) + 9'(d8_b) + 9'(d8_cin);
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_res  <= m_pend;
            end
        end else if (d8_done_ready) begin
            m_done <= 1'b0;
            m_idle <= 1'b1;
        end
    end

    // Compare process: every negedge, handshake outputs always; result whenever it is meaningful.
    always @(negedge clk) begin
        check("start_ready", 64'(d8_start_ready), 64'(m_idle));
        check("busy", 64'(d8_busy), 64'(!m_idle));
        check("done_valid", 64'(d8_done_valid), 64'(m_done));
        if (m_idle || m_done) begin
            check("sum", 64'(d8_sum), 64'(m_res[7:0]));
            check("cout", 64'(d8_cout), 64'(m_res[8]));
        end
    end

    initial $monitor("%0t u_dut4 done_valid=%b", $time, d4_done_valid);

    // Called at a negedge with the 8-bit DUT idle; returns at a negedge with it idle again.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic [7:0] es, input logic ec);
        int n;
        bit seen;
        d8_a = ta;
        d8_b = tb_v;
        d8_cin = tc;
        d8_start_valid = 1'b1;
        @(negedge clk);
        d8_start_valid = 1'b0;
        d8_a = ~ta;
        d8_b = ~tb_v;
        d8_cin = ~tc;
        n = 1;
        seen = 1'b0;
        while (!seen && n < 30) begin
            if (d8_done_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check("latency", 64'(n), 64'd9);
        check("lit_sum", 64'(d8_sum), 64'(es));
        check("lit_cout", 64'(d8_cout), 64'(ec));
        @(negedge clk);
    endtask

    initial begin
        int n;
        int sr_cnt;
        int dv_cnt;
        bit seen;
        logic [8:0] v;

        // Reset values.
        #12;
        check("rst_sum", 64'(d8_sum), 64'd0);
        check("rst_cout", 64'(d8_cout), 64'd0);
        check("rst_done_valid", 64'(d8_done_valid), 64'd0);
        check("rst_busy", 64'(d8_busy), 64'd0);
        check("rst_start_ready", 64'(d8_start_ready), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Directed operand sets.
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        run_op(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0);

        // Backpressure: result held while new operands are offered.
        d8_done_ready = 1'b0;
        d8_a = 8'h3C;
        d8_b = 8'hC3;
        d8_cin = 1'b0;
        d8_start_valid = 1'b1;
        @(negedge clk);
        d8_start_valid = 1'b0;
        n = 0;
        while (!d8_done_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("bp_reached_done", 64'(d8_done_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            d8_a = 8'h11;
            d8_b = 8'h22;
            d8_start_valid = 1'b1;
            @(negedge clk);
            check("bp_hold_valid", 64'(d8_done_valid), 64'd1);
            check("bp_hold_sum", 64'({d8_cout, d8_sum}), 64'h0FF);
            check("bp_no_accept", 64'(d8_start_ready), 64'd0);
        end
        d8_done_ready = 1'b1;
        @(negedge clk);
        d8_start_valid = 1'b0;
        run_op(8'h11, 8'h22, 1'b0, 8'h33, 1'b0);

        // Continuous start_valid: one accept and one done every WIDTH+2 cycles.
        sr_cnt = 0;
        dv_cnt = 0;
        d8_start_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (d8_start_ready) sr_cnt++;
            if (d8_done_valid) dv_cnt++;
            d8_a = 8'(8'h13 * i + 8'h07);
            d8_b = 8'(8'h29 * i + 8'hC1);
            d8_cin = 1'(i);
            @(negedge clk);
        end
        d8_start_valid = 1'b0;
        check("cont_start_ready_pulses", 64'(sr_cnt), 64'd4);
        check("cont_done_pulses", 64'(dv_cnt), 64'd4);
        @(negedge clk);

        // Asynchronous reset in the 3rd RUN cycle.
        d8_a = 8'h55;
        d8_b = 8'h66;
        d8_cin = 1'b0;
        d8_start_valid = 1'b1;
        @(negedge clk);
        d8_start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sum", 64'(d8_sum), 64'd0);
        check("arst_cout", 64'(d8_cout), 64'd0);
        check("arst_done_valid", 64'(d8_done_valid), 64'd0);
        check("arst_busy", 64'(d8_busy), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (d8_done_valid) seen = 1'b1;
        end
        check("arst_no_done", 64'(seen), 64'd0);
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // WIDTH=4 exhaustive.
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            d4_a = v[3:0];
            d4_b = v[7:4];
            d4_cin = v[8];
            d4_start_valid = 1'b1;
            @(negedge clk);
            d4_start_valid = 1'b0;
            n = 0;
            while (!d4_done_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("w4_sum", 64'({d4_cout, d4_sum}),
                  64'(5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8])));
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
